// File: rtl/ramdisk_axi_responder_pkg.sv
// Shared definitions for the RAM-disk AXI responder.
// Holds the AXI response and burst codes, the responder FSM state
// encoding, and the size of one disk block.
package ramdisk_axi_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // One disk block is 128 beats of 4 bytes.
  localparam int unsigned DISK_BLOCK_BEATS = 128;
  localparam int unsigned DISK_BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_WRESP  = 3'd2,
    ST_RFETCH = 3'd3,
    ST_RDATA  = 3'd4
  } state_t;

endpackage

// File: rtl/ramdisk_axi_responder_bram.sv
// Backing RAM of the RAM disk: single port, 32-bit words, per-byte write
// enables, synchronous read with one cycle of latency (read-first).
// Ports:
//   ramclk - clock
//   en     - port enable; rdata only updates when en is high
//   we     - byte write enables (bit i covers wdata[8i+7:8i])
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data
// Contents are not reset.
module ramdisk_bram #(
  parameter int MEM_AW = 14
) (
  input  logic              ramclk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge ramclk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ramdisk_axi_responder.sv
// AXI4 slave front end for a RAM disk. Serves one transaction at a time;
// every burst is treated as INCR of 4-byte beats and addresses wrap modulo
// the RAM size.
// Ports:
//   ui_clk, ui_clk_sync_rst_n - clock and synchronous active-low reset
//   s_axi_aw*                 - write address channel (size/burst ignored)
//   s_axi_w*                  - write data channel
//   s_axi_b*                  - write response channel
//   s_axi_ar*                 - read address channel (size/burst ignored)
//   s_axi_r*                  - read data channel
module ramdisk_axi_responder
  import ramdisk_axi_responder_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic        ui_clk,
  input  logic        ui_clk_sync_rst_n,
  input  logic [3:0]  s_axi_awid,
  input  logic [27:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [27:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam logic [MEM_AW-1:0] ADDR_ONE = 1;

  state_t state_q, state_d;

  logic [3:0]        bid_q, rid_q;
  logic [1:0]        bresp_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic              over_q;   // write beats past len are being discarded
  logic [MEM_AW-1:0] addr_q;   // word address of the current beat

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [31:0]       ram_rdata;

  logic w_hs, r_hs, len_hit;

  logic unused_fields;
  assign unused_fields = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                           s_axi_awaddr[27:MEM_AW+2], s_axi_awaddr[1:0],
                           s_axi_araddr[27:MEM_AW+2], s_axi_araddr[1:0]};

  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign len_hit = (beat_q == len_q);

  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_axi_awready = 1'b1;
        // A pending write takes priority, so the read is held off this cycle.
        s_axi_arready = ~s_axi_awvalid;
        if (s_axi_awvalid) begin
          state_d = ST_WDATA;
        end else if (s_axi_arvalid) begin
          state_d = ST_RFETCH;
        end
      end
      ST_WDATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
          state_d = ST_IDLE;
        end
      end
      ST_RFETCH: begin
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = len_hit;
        if (s_axi_rready && len_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port. The RAM read register doubles as the R-channel data register:
  // it only reloads on a beat handshake (prefetching addr+1), so rdata holds
  // steady while the initiator stalls.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = addr_q;
    case (state_q)
      ST_WDATA: begin
        ram_en = s_axi_wvalid;
        ram_we = (s_axi_wvalid && !over_q) ? s_axi_wstrb : '0;
      end
      ST_RFETCH: begin
        ram_en = 1'b1;
      end
      ST_RDATA: begin
        if (s_axi_rready) begin
          ram_en   = 1'b1;
          ram_addr = addr_q + ADDR_ONE;
        end
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
    if (!ui_clk_sync_rst_n) begin
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst_n) begin
      bid_q   <= '0;
      rid_q   <= '0;
      bresp_q <= RESP_OKAY;
      len_q   <= '0;
      beat_q  <= '0;
      over_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          beat_q <= '0;
          over_q <= 1'b0;
          if (s_axi_awvalid) begin
            bid_q  <= s_axi_awid;
            len_q  <= s_axi_awlen;
            addr_q <= s_axi_awaddr[MEM_AW+1:2];
          end else if (s_axi_arvalid) begin
            rid_q  <= s_axi_arid;
            len_q  <= s_axi_arlen;
            addr_q <= s_axi_araddr[MEM_AW+1:2];
          end
        end
        ST_WDATA: begin
          if (w_hs) begin
            addr_q <= addr_q + ADDR_ONE;
            if (!over_q) begin
              beat_q <= beat_q + 8'd1;
              if (len_hit) begin
                over_q <= 1'b1;
              end
            end
            if (s_axi_wlast) begin
              bresp_q <= (!over_q && len_hit) ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        ST_RDATA: begin
          if (r_hs) begin
            addr_q <= addr_q + ADDR_ONE;
            beat_q <= beat_q + 8'd1;
          end
        end
        default: begin
          beat_q <= beat_q;
        end
      endcase
    end
  end

  assign s_axi_bid   = bid_q;
  assign s_axi_bresp = bresp_q;
  assign s_axi_rid   = rid_q;
  assign s_axi_rresp = RESP_OKAY;
  assign s_axi_rdata = ram_rdata;

  ramdisk_bram #(.MEM_AW(MEM_AW)) u_bram (
    .ramclk (ui_clk),
    .en     (ram_en),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (s_axi_wdata),
    .rdata  (ram_rdata)
  );

endmodule

// File: tb/tb_ramdisk_axi_responder.sv
// Directed self-checking bench for ramdisk_axi_responder.
module tb_ramdisk_axi_responder;

  logic        ui_clk = 1'b0;
  logic        ui_clk_sync_rst_n = 1'b0;
  logic [3:0]  s_axi_awid = '0;
  logic [27:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_arid = '0;
  logic [27:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  always #5 ui_clk = ~ui_clk;

  ramdisk_axi_responder #(.MEM_AW(14)) dut (
    .ui_clk            (ui_clk),
    .ui_clk_sync_rst_n (ui_clk_sync_rst_n),
    .s_axi_awid        (s_axi_awid),
    .s_axi_awaddr      (s_axi_awaddr),
    .s_axi_awlen       (s_axi_awlen),
    .s_axi_awsize      (s_axi_awsize),
    .s_axi_awburst     (s_axi_awburst),
    .s_axi_awvalid     (s_axi_awvalid),
    .s_axi_awready     (s_axi_awready),
    .s_axi_wdata       (s_axi_wdata),
    .s_axi_wstrb       (s_axi_wstrb),
    .s_axi_wlast       (s_axi_wlast),
    .s_axi_wvalid      (s_axi_wvalid),
    .s_axi_wready      (s_axi_wready),
    .s_axi_bid         (s_axi_bid),
    .s_axi_bresp       (s_axi_bresp),
    .s_axi_bvalid      (s_axi_bvalid),
    .s_axi_bready      (s_axi_bready),
    .s_axi_arid        (s_axi_arid),
    .s_axi_araddr      (s_axi_araddr),
    .s_axi_arlen       (s_axi_arlen),
    .s_axi_arsize      (s_axi_arsize),
    .s_axi_arburst     (s_axi_arburst),
    .s_axi_arvalid     (s_axi_arvalid),
    .s_axi_arready     (s_axi_arready),
    .s_axi_rid         (s_axi_rid),
    .s_axi_rdata       (s_axi_rdata),
    .s_axi_rresp       (s_axi_rresp),
    .s_axi_rlast       (s_axi_rlast),
    .s_axi_rvalid      (s_axi_rvalid),
    .s_axi_rready      (s_axi_rready)
  );

  int total = 0;
  int bad = 0;

  // Results of the last run_write / run_read.
  int          wr_beats, wr_tmo;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  logic [31:0] rd_data [0:255];
  logic        rd_last [0:255];
  int          rd_cnt, rd_lat, rd_stall_bad, rd_tmo, rd_first_cyc, rd_last_cyc, rd_ar_at_last;
  logic [3:0]  rd_rid;

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic run_write(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                           input int nbeats, input logic [31:0] base, input logic [3:0] strb);
    int k;
    wr_beats = 0;
    wr_tmo   = 0;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    k = 0;
    @(negedge ui_clk);
    while (!s_axi_awready && k < 50) begin step(); @(negedge ui_clk); k++; end
    if (k >= 50) wr_tmo++;
    step();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi_wdata = base + i; s_axi_wstrb = strb; s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
      k = 0;
      @(negedge ui_clk);
      while (!s_axi_wready && k < 50) begin step(); @(negedge ui_clk); k++; end
      if (k >= 50) wr_tmo++; else wr_beats++;
      step();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    k = 0;
    @(negedge ui_clk);
    while (!s_axi_bvalid && k < 50) begin step(); @(negedge ui_clk); k++; end
    if (k >= 50) wr_tmo++;
    wr_resp = s_axi_bresp;
    wr_bid  = s_axi_bid;
    step();
    s_axi_bready = 1'b0;
  endtask

  // abort_beat >= 0: assert reset when that beat is presented (returns at the
  // negedge with reset low, before the edge that applies it).
  task automatic run_read(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                          input bit toggle, input int abort_beat);
    int k, c;
    bit stalled;
    logic [31:0] pd;
    logic pl;
    rd_cnt = 0; rd_lat = -1; rd_stall_bad = 0; rd_tmo = 0; rd_ar_at_last = -1;
    rd_first_cyc = 0; rd_last_cyc = 0; rd_rid = 'x;
    stalled = 0; pd = '0; pl = 1'b0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    k = 0;
    @(negedge ui_clk);
    while (!s_axi_arready && k < 50) begin step(); @(negedge ui_clk); k++; end
    if (k >= 50) rd_tmo++;
    step();
    s_axi_arvalid = 1'b0;
    c = 1;
    while (c < 1000) begin
      s_axi_rready = toggle ? ((c % 2) == 0) : 1'b1;
      @(negedge ui_clk);
      if (s_axi_rvalid) begin
        if (rd_lat < 0) begin rd_lat = c; rd_first_cyc = c; rd_rid = s_axi_rid; end
        if (stalled && (s_axi_rdata !== pd || s_axi_rlast !== pl)) rd_stall_bad++;
        if (abort_beat >= 0 && rd_cnt == abort_beat) begin ui_clk_sync_rst_n = 1'b0; break; end
        if (s_axi_rready) begin
          if (rd_cnt < 256) begin rd_data[rd_cnt] = s_axi_rdata; rd_last[rd_cnt] = s_axi_rlast; end
          rd_cnt++;
          stalled = 0;
          if (s_axi_rlast) begin
            rd_ar_at_last = s_axi_arready; rd_last_cyc = c;
            step();
            break;
          end
        end else begin
          stalled = 1; pd = s_axi_rdata; pl = s_axi_rlast;
        end
      end
      step();
      c++;
    end
    if (c >= 1000) rd_tmo++;
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    ui_clk_sync_rst_n = 1'b0;
    repeat (3) step();
    @(negedge ui_clk);
    total++; if (s_axi_awready !== 1'b1) begin bad++; $display("FAIL reset_awready: got %b want 1", s_axi_awready); end
    total++; if (s_axi_arready !== 1'b1) begin bad++; $display("FAIL reset_arready: got %b want 1", s_axi_arready); end
    total++; if (s_axi_wready !== 1'b0) begin bad++; $display("FAIL reset_wready: got %b want 0", s_axi_wready); end
    total++; if (s_axi_bvalid !== 1'b0) begin bad++; $display("FAIL reset_bvalid: got %b want 0", s_axi_bvalid); end
    total++; if (s_axi_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", s_axi_rvalid); end
    total++; if (s_axi_rlast !== 1'b0) begin bad++; $display("FAIL reset_rlast: got %b want 0", s_axi_rlast); end
    total++; if (s_axi_bresp !== 2'b00) begin bad++; $display("FAIL reset_bresp: got %b want 00", s_axi_bresp); end
    total++; if (s_axi_rresp !== 2'b00) begin bad++; $display("FAIL reset_rresp: got %b want 00", s_axi_rresp); end
    total++; if (s_axi_bid !== 4'h0) begin bad++; $display("FAIL reset_bid: got %h want 0", s_axi_bid); end
    total++; if (s_axi_rid !== 4'h0) begin bad++; $display("FAIL reset_rid: got %h want 0", s_axi_rid); end
    step();
    ui_clk_sync_rst_n = 1'b1;
    step();
  endtask

  task automatic test_block_write();
    run_write(4'h5, 28'h200, 8'd127, 128, 32'h0, 4'hF);
    total++; if (wr_tmo !== 0) begin bad++; $display("FAIL blkwr_timeout: got %0d want 0", wr_tmo); end
    total++; if (wr_beats !== 128) begin bad++; $display("FAIL blkwr_beats: got %0d want 128", wr_beats); end
    total++; if (wr_resp !== 2'b00) begin bad++; $display("FAIL blkwr_bresp: got %b want 00", wr_resp); end
    total++; if (wr_bid !== 4'h5) begin bad++; $display("FAIL blkwr_bid: got %h want 5", wr_bid); end
  endtask

  task automatic test_block_read();
    int derr, lerr;
    run_read(4'h9, 28'h200, 8'd127, 1'b0, -1);
    derr = 0; lerr = 0;
    for (int i = 0; i < 128; i++) begin
      if (rd_data[i] !== i) derr++;
      if (rd_last[i] !== (i == 127)) lerr++;
    end
    total++; if (rd_tmo !== 0) begin bad++; $display("FAIL blkrd_timeout: got %0d want 0", rd_tmo); end
    total++; if (rd_lat !== 2) begin bad++; $display("FAIL blkrd_latency: got %0d want 2", rd_lat); end
    total++; if (rd_cnt !== 128) begin bad++; $display("FAIL blkrd_count: got %0d want 128", rd_cnt); end
    total++; if (derr !== 0) begin bad++; $display("FAIL blkrd_data: got %0d wrong beats want 0", derr); end
    total++; if (lerr !== 0) begin bad++; $display("FAIL blkrd_rlast: got %0d wrong beats want 0", lerr); end
    total++; if (rd_rid !== 4'h9) begin bad++; $display("FAIL blkrd_rid: got %h want 9", rd_rid); end
    total++; if (rd_last_cyc - rd_first_cyc !== 127) begin bad++; $display("FAIL blkrd_streaming: got span %0d want 127", rd_last_cyc - rd_first_cyc); end
    total++; if (rd_ar_at_last !== 0) begin bad++; $display("FAIL blkrd_arready_at_rlast: got %0d want 0", rd_ar_at_last); end
    @(negedge ui_clk);
    total++; if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1) begin bad++; $display("FAIL blkrd_idle_after: got ar=%b aw=%b want 1 1", s_axi_arready, s_axi_awready); end
    step();
  endtask

  task automatic test_rready_toggle();
    int derr, lerr;
    run_read(4'hA, 28'h200, 8'd127, 1'b1, -1);
    derr = 0; lerr = 0;
    for (int i = 0; i < 128; i++) begin
      if (rd_data[i] !== i) derr++;
      if (rd_last[i] !== (i == 127)) lerr++;
    end
    total++; if (rd_tmo !== 0) begin bad++; $display("FAIL toggle_timeout: got %0d want 0", rd_tmo); end
    total++; if (rd_cnt !== 128) begin bad++; $display("FAIL toggle_count: got %0d want 128", rd_cnt); end
    total++; if (derr !== 0) begin bad++; $display("FAIL toggle_data: got %0d wrong beats want 0", derr); end
    total++; if (lerr !== 0) begin bad++; $display("FAIL toggle_rlast: got %0d wrong beats want 0", lerr); end
    total++; if (rd_stall_bad !== 0) begin bad++; $display("FAIL toggle_stall_stable: got %0d changes want 0", rd_stall_bad); end
  endtask

  task automatic test_simultaneous();
    int arbad, k, n;
    logic [31:0] d [0:1];
    logic [3:0] rid;
    s_axi_awid = 4'h3; s_axi_awaddr = 28'h1000; s_axi_awlen = 8'd1; s_axi_awvalid = 1'b1;
    s_axi_arid = 4'h4; s_axi_araddr = 28'h1000; s_axi_arlen = 8'd1; s_axi_arvalid = 1'b1;
    @(negedge ui_clk);
    total++; if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin bad++; $display("FAIL simul_priority: got aw=%b ar=%b want 1 0", s_axi_awready, s_axi_arready); end
    step();
    s_axi_awvalid = 1'b0;
    arbad = 0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wdata = 32'hA5A50000 + i; s_axi_wstrb = 4'hF; s_axi_wlast = (i == 1); s_axi_wvalid = 1'b1;
      @(negedge ui_clk);
      if (s_axi_arready !== 1'b0 || s_axi_wready !== 1'b1) arbad++;
      step();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    @(negedge ui_clk);
    if (s_axi_arready !== 1'b0) arbad++;
    total++; if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_bid !== 4'h3) begin bad++; $display("FAIL simul_bresp: got v=%b r=%b id=%h want 1 00 3", s_axi_bvalid, s_axi_bresp, s_axi_bid); end
    total++; if (arbad !== 0) begin bad++; $display("FAIL simul_ar_held: got %0d cycles want 0", arbad); end
    step();
    s_axi_bready = 1'b0;
    @(negedge ui_clk);
    total++; if (s_axi_arready !== 1'b1) begin bad++; $display("FAIL simul_ar_after_b: got %b want 1", s_axi_arready); end
    step();
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    n = 0; k = 0; rid = 'x; d[0] = 'x; d[1] = 'x;
    while (n < 2 && k < 50) begin
      @(negedge ui_clk);
      if (s_axi_rvalid) begin d[n] = s_axi_rdata; rid = s_axi_rid; n++; end
      step();
      k++;
    end
    s_axi_rready = 1'b0;
    total++; if (n !== 2) begin bad++; $display("FAIL simul_read_beats: got %0d want 2", n); end
    total++; if (d[0] !== 32'hA5A50000 || d[1] !== 32'hA5A50001) begin bad++; $display("FAIL simul_read_data: got %h %h want a5a50000 a5a50001", d[0], d[1]); end
    total++; if (rid !== 4'h4) begin bad++; $display("FAIL simul_rid: got %h want 4", rid); end
  endtask

  task automatic test_wlast_errors();
    run_write(4'h1, 28'h2000, 8'd3, 3, 32'h0, 4'hF);
    total++; if (wr_resp !== 2'b10 || wr_beats !== 3) begin bad++; $display("FAIL short_burst: got resp=%b beats=%0d want 10 3", wr_resp, wr_beats); end
    run_write(4'h2, 28'h3000, 8'd5, 6, 32'hEEEE0000, 4'hF);
    total++; if (wr_resp !== 2'b00) begin bad++; $display("FAIL prefill_resp: got %b want 00", wr_resp); end
    run_write(4'h2, 28'h3000, 8'd3, 6, 32'h100, 4'hF);
    total++; if (wr_resp !== 2'b10 || wr_beats !== 6) begin bad++; $display("FAIL long_burst: got resp=%b beats=%0d want 10 6", wr_resp, wr_beats); end
    run_read(4'h6, 28'h3000, 8'd5, 1'b0, -1);
    total++; if (rd_cnt !== 6 || rd_data[0] !== 32'h100 || rd_data[3] !== 32'h103 ||
                 rd_data[4] !== 32'hEEEE0004 || rd_data[5] !== 32'hEEEE0005) begin
      bad++; $display("FAIL long_burst_discard: got n=%0d %h %h %h %h want 6 100 103 eeee0004 eeee0005",
                      rd_cnt, rd_data[0], rd_data[3], rd_data[4], rd_data[5]);
    end
    run_write(4'h3, 28'h4000, 8'd0, 1, 32'h11223344, 4'hF);
    run_write(4'h3, 28'h4000, 8'd0, 1, 32'hAABBCCDD, 4'b0011);
    total++; if (wr_resp !== 2'b00) begin bad++; $display("FAIL single_write_resp: got %b want 00", wr_resp); end
    run_read(4'h7, 28'h4000, 8'd0, 1'b0, -1);
    total++; if (rd_cnt !== 1 || rd_last[0] !== 1'b1) begin bad++; $display("FAIL single_read: got n=%0d last=%b want 1 1", rd_cnt, rd_last[0]); end
    total++; if (rd_data[0] !== 32'h1122CCDD) begin bad++; $display("FAIL partial_strobe: got %h want 1122ccdd", rd_data[0]); end
  endtask

  task automatic test_wrap();
    run_write(4'h4, 28'h40, 8'd0, 1, 32'hCAFE0040, 4'hF);
    run_read(4'h4, 28'h10043, 8'd0, 1'b0, -1);
    total++; if (rd_data[0] !== 32'hCAFE0040) begin bad++; $display("FAIL addr_alias: got %h want cafe0040", rd_data[0]); end
    run_write(4'h5, 28'hFFFC, 8'd1, 2, 32'hBEEF0000, 4'hF);
    run_read(4'h5, 28'h0, 8'd0, 1'b0, -1);
    total++; if (rd_data[0] !== 32'hBEEF0001) begin bad++; $display("FAIL write_wrap: got %h want beef0001", rd_data[0]); end
    run_read(4'h5, 28'hFFFC, 8'd1, 1'b0, -1);
    total++; if (rd_cnt !== 2 || rd_data[0] !== 32'hBEEF0000 || rd_data[1] !== 32'hBEEF0001) begin
      bad++; $display("FAIL read_wrap: got n=%0d %h %h want 2 beef0000 beef0001", rd_cnt, rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    int derr;
    run_read(4'hB, 28'h200, 8'd127, 1'b0, 40);
    total++; if (rd_cnt !== 40) begin bad++; $display("FAIL abort_beats: got %0d want 40", rd_cnt); end
    step();
    @(negedge ui_clk);
    total++; if (s_axi_rvalid !== 1'b0) begin bad++; $display("FAIL abort_rvalid: got %b want 0", s_axi_rvalid); end
    total++; if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1) begin bad++; $display("FAIL abort_idle: got ar=%b aw=%b want 1 1", s_axi_arready, s_axi_awready); end
    step();
    ui_clk_sync_rst_n = 1'b1;
    step();
    run_read(4'hC, 28'h200, 8'd127, 1'b0, -1);
    derr = 0;
    for (int i = 0; i < 128; i++) if (rd_data[i] !== i) derr++;
    total++; if (rd_cnt !== 128 || derr !== 0) begin bad++; $display("FAIL reread_after_reset: got n=%0d errs=%0d want 128 0", rd_cnt, derr); end
  endtask

  initial begin
    test_reset();
    test_block_write();
    test_block_read();
    test_rready_toggle();
    test_simultaneous();
    test_wlast_errors();
    test_wrap();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ramdisk_axi_responder.md
RAMDISK_AXI_RESPONDER -- requirements
Module: ramdisk_axi_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 14, word-address width of the backing RAM (2^MEM_AW 32-bit words).
REQ-002 SHALL have these ports (clock and reset first):
- ui_clk  in  1  sole clock.
- ui_clk_sync_rst_n  in  1  reset, synchronous, active-low.
- s_axi_awid  in  4  write ID.
- s_axi_awaddr  in  28  write byte address.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3  ignored.
- s_axi_awburst  in  2  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wlast  in  1  final write beat.
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake.
- s_axi_bid  out  4  response ID.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake.
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  4/28/8/3/2  read address fields, same meaning as the AW fields.
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake.
- s_axi_rid  out  4  read ID.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  final read beat.
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake.
REQ-003 SHALL omit lock/cache/prot/qos ports; the initiator ties them off.

Function
REQ-004 SHALL run FSM states IDLE, WDATA, WRESP, RFETCH, RDATA, one transaction at a time.
REQ-005 IDLE: awready=arready=1. On awvalid, go to WDATA. Otherwise on arvalid, go to RFETCH. Both valid in the same cycle: write wins and arready SHALL be 0 that cycle.
REQ-006 On address handshake, SHALL latch ID, len, and word address = addr[MEM_AW+1:2]. Address bits [1:0] and [27:MEM_AW+2] are ignored, so addresses wrap modulo RAM size.
REQ-007 Every burst SHALL be treated as INCR of 4-byte beats; word address increments by 1 per beat and wraps at 2^MEM_AW.
REQ-008 WDATA: wready=1. Each beat with beat count <= len writes wdata to RAM under wstrb per byte. Beats beyond len SHALL be accepted and discarded.
REQ-009 WDATA SHALL exit to WRESP on the beat with wlast=1. bresp = OKAY (00) if that beat's count == len, else SLVERR (10).
REQ-010 WRESP: bvalid=1 with latched bid; hold until bready, then return to IDLE.
REQ-011 RFETCH SHALL last exactly one cycle to cover the synchronous RAM read. rvalid SHALL rise 2 cycles after the AR handshake.
REQ-012 RDATA: rvalid=1, rresp=OKAY, rid latched, rlast=1 on beat len. Outputs SHALL stay stable while rready=0.
REQ-013 With rready held 1, RDATA SHALL deliver one beat per cycle by prefetching the next address on each handshake.
REQ-014 After the rlast handshake, SHALL return to IDLE. awready/arready SHALL be 1 no earlier than the next cycle.
REQ-015 len=0 SHALL give a single beat with rlast=1, or a single write beat.
REQ-016 awready, arready, wready, bvalid, and rvalid SHALL each be 0 outside the states listed above.

Reset
REQ-017 With ui_clk_sync_rst_n=0 at a clock edge, SHALL enter IDLE and force awready=arready=1 and wready=bvalid=rvalid=rlast=0. bresp, rresp, bid, rid SHALL be 0.
REQ-018 Reset mid-burst SHALL abandon the transaction with no response. RAM contents SHALL be preserved. Beats already written SHALL remain.

Structure
REQ-019 SHALL define in a shared package: AXI response codes OKAY/SLVERR, burst-type codes, FSM state enum, and the 128-beat (512-byte) disk block constant.
REQ-020 SHALL place the RAM in one sub-module, ramdisk_bram: single port, byte-write, synchronous read, 1-cycle latency, parameter MEM_AW.

Verification
REQ-021 Reset, then write awaddr=0x200, awlen=127, data = beat index, wstrb=F -> 128 wready beats, then bvalid with bresp=00, bid echoed.
REQ-022 Read araddr=0x200, arlen=127, rready=1 -> rvalid 2 cycles after AR handshake; 128 consecutive beats with data 0..127; rlast only on beat 127.
REQ-023 Same read with rready toggled 1/0 every cycle -> data sequence unchanged, no beat lost or duplicated, rdata stable while stalled.
REQ-024 awvalid and arvalid asserted in the same cycle -> write accepted first, arready=0 that cycle; read accepted after the bready handshake.
REQ-025 awlen=3 with wlast on beat 2 -> bresp=10. awlen=3 with wlast on beat 5 -> beats 4-5 discarded, bresp=10. Partial wstrb=0011 -> only low 2 bytes change.
REQ-026 Reset asserted at read beat 40 -> rvalid=0 the next cycle, IDLE with arready=1; a re-read of the block returns the data written in REQ-021.
